// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the command FSM / readout logic (master) and the
// UART TX arbiter (slave); the tx_* side faces the UART core.
interface uart_tx_arbiter_if #(
   parameter int unsigned CMD_DEPTH = 4
);
   localparam int unsigned LW = $clog2(CMD_DEPTH) + 1;

   logic [7:0]    cmd_data;
   logic          cmd_wr;
   logic [7:0]    stream_data;
   logic          stream_valid;
   logic          stream_last;
   logic          stream_ready;
   logic [7:0]    tx_data;
   logic          tx_wr;
   logic          tx_busy;
   logic          clr_overflow;
   logic          cmd_overflow;
   logic [LW-1:0] cmd_level;

   modport master (
      output cmd_data, cmd_wr, stream_data, stream_valid, stream_last,
             tx_busy, clr_overflow,
      input  stream_ready, tx_data, tx_wr, cmd_overflow, cmd_level
   );

   modport slave (
      input  cmd_data, cmd_wr, stream_data, stream_valid, stream_last,
             tx_busy, clr_overflow,
      output stream_ready, tx_data, tx_wr, cmd_overflow, cmd_level
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between buffered command bytes and a
// packet-locked valid/ready sample stream.
module uart_tx_arbiter #(
   parameter int unsigned CMD_DEPTH = 4
) (
   input logic              clk,
   input logic              rst,
   uart_tx_arbiter_if.slave bus
);
   localparam int unsigned AW = $clog2(CMD_DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic [1:0] {IDLE, SEND, HOLD, WAIT} state_t;

   state_t        state_q, state_d;
   logic [7:0]    mem_q [CMD_DEPTH];
   logic [7:0]    mem_d [CMD_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          lock_q, lock_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_wr_q, tx_wr_d;
   logic          ovf_q, ovf_d;

   logic idle, empty, full, pop, push, drop, ready;

   always_comb begin
      idle  = (state_q == IDLE);
      empty = (level_q == '0);
      full  = (level_q == LW'(CMD_DEPTH));
      pop   = idle && !lock_q && !empty;
      // Mutually exclusive with pop: the stream is served only when locked or the FIFO is empty.
      ready = idle && bus.stream_valid && (lock_q || empty);
      push  = bus.cmd_wr && (!full || pop);
      drop  = bus.cmd_wr && full && !pop;

      state_d   = state_q;
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      lock_d    = lock_q;
      tx_data_d = tx_data_q;
      tx_wr_d   = 1'b0;
      ovf_d     = ovf_q;

      if (push) begin
         mem_d[wr_ptr_q] = bus.cmd_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d  = rd_ptr_q + 1'b1;
         tx_data_d = mem_q[rd_ptr_q];
      end
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (pop && !push) begin
         level_d = level_q - 1'b1;
      end

      if (ready) begin
         tx_data_d = bus.stream_data;
         lock_d    = !bus.stream_last;
      end

      if (drop) begin
         ovf_d = 1'b1;
      end else if (bus.clr_overflow) begin
         ovf_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (pop || ready) begin
               state_d = SEND;
               tx_wr_d = 1'b1;
            end
         end
         SEND: state_d = HOLD;
         HOLD: state_d = WAIT;
         WAIT: begin
            if (!bus.tx_busy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         lock_q    <= 1'b0;
         tx_data_q <= '0;
         tx_wr_q   <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         lock_q    <= lock_d;
         tx_data_q <= tx_data_d;
         tx_wr_q   <= tx_wr_d;
         ovf_q     <= ovf_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and level.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign bus.stream_ready = ready;
   assign bus.tx_data      = tx_data_q;
   assign bus.tx_wr        = tx_wr_q;
   assign bus.cmd_overflow = ovf_q;
   assign bus.cmd_level    = level_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of uart_tx_arbiter against a transaction-level
// model: a command byte queue, a packet lock bit and a next-grant-time counter.
module tb_uart_tx_arbiter;
   localparam int unsigned D = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.CMD_DEPTH(D)) bus ();
   uart_tx_arbiter #(.CMD_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state
   logic [7:0] mq [$];
   logic       m_lock;
   logic       m_ovf;
   logic [7:0] m_tx;
   logic       m_wr;
   int         m_avail;

   // Environment: UART busy model, stream source, output log
   int         busy_len;
   int         pend_b;
   int         busy_cnt;
   logic       sv_gate;
   logic [8:0] sq [$];
   logic [7:0] log_q [$];
   int         wr_cyc [$];
   logic [7:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_stream();
      bus.stream_valid = (sq.size() > 0) && sv_gate;
      bus.stream_data  = (sq.size() > 0) ? sq[0][7:0] : 8'h00;
      bus.stream_last  = (sq.size() > 0) ? sq[0][8] : 1'b0;
   endtask

   // One clock: check ready, advance the model across the edge, check outputs.
   task automatic tick();
      logic exp_rdy, grant_cmd, drop, sent;
      int   gap;
      #1;
      exp_rdy = (cyc >= m_avail) && bus.stream_valid && (m_lock || mq.size() == 0);
      chk("stream_ready", {31'd0, bus.stream_ready}, {31'd0, exp_rdy});
      sent      = bus.tx_wr;
      grant_cmd = (cyc >= m_avail) && !m_lock && (mq.size() > 0);
      m_wr      = 1'b0;
      if (grant_cmd) m_tx = mq.pop_front();
      if (exp_rdy) begin
         m_tx   = bus.stream_data;
         m_lock = !bus.stream_last;
         void'(sq.pop_front());
      end
      if (grant_cmd || exp_rdy) begin
         m_wr    = 1'b1;
         pend_b  = busy_len;
         gap     = (busy_len + 3 > 4) ? busy_len + 3 : 4;
         m_avail = cyc + gap;
      end
      drop = bus.cmd_wr && (mq.size() == D);
      if (drop) m_ovf = 1'b1;
      else if (bus.clr_overflow) m_ovf = 1'b0;
      if (bus.cmd_wr && !drop) mq.push_back(bus.cmd_data);

      @(posedge clk);
      @(negedge clk);
      cyc++;
      bus.cmd_wr       = 1'b0;
      bus.clr_overflow = 1'b0;
      if (sent) busy_cnt = pend_b;
      else if (busy_cnt > 0) busy_cnt--;
      bus.tx_busy = (busy_cnt > 0);

      chk("tx_wr", {31'd0, bus.tx_wr}, {31'd0, m_wr});
      chk("tx_data", {24'd0, bus.tx_data}, {24'd0, m_tx});
      chk("cmd_level", {29'd0, bus.cmd_level}, mq.size());
      chk("cmd_overflow", {31'd0, bus.cmd_overflow}, {31'd0, m_ovf});
      if (bus.tx_wr) begin
         log_q.push_back(bus.tx_data);
         wr_cyc.push_back(cyc);
      end
      drive_stream();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic cmd(input logic [7:0] b);
      bus.cmd_data = b;
      bus.cmd_wr   = 1'b1;
      tick();
   endtask

   task automatic check_log(input string tag);
      chk({tag, "_count"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
         chk(tag, {24'd0, log_q[i]}, {24'd0, exp_q[i]});
      log_q.delete();
      wr_cyc.delete();
      exp_q.delete();
   endtask

   task automatic model_reset();
      mq.delete();
      sq.delete();
      m_lock  = 1'b0;
      m_ovf   = 1'b0;
      m_tx    = 8'h00;
      m_wr    = 1'b0;
      m_avail = cyc;
   endtask

   initial begin
      logic ok;
      rst = 1'b1;
      bus.cmd_data = 8'h00; bus.cmd_wr = 1'b0;
      bus.stream_data = 8'h00; bus.stream_valid = 1'b0; bus.stream_last = 1'b0;
      bus.tx_busy = 1'b0; bus.clr_overflow = 1'b0;
      busy_len = 0; pend_b = 0; busy_cnt = 0; sv_gate = 1'b1;
      @(negedge clk);
      chk("rst_tx_wr", {31'd0, bus.tx_wr}, 32'd0);
      chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
      chk("rst_level", {29'd0, bus.cmd_level}, 32'd0);
      chk("rst_ovf", {31'd0, bus.cmd_overflow}, 32'd0);
      chk("rst_ready", {31'd0, bus.stream_ready}, 32'd0);
      model_reset();
      rst = 1'b0;

      // Single command byte with a slow UART, then a second one queued behind it
      busy_len = 20;
      cmd(8'h2A);
      chk("single_level", {29'd0, bus.cmd_level}, 32'd1);
      run(5);
      cmd(8'h2B);
      run(40);
      ok = (wr_cyc.size() >= 2) && (wr_cyc[1] - wr_cyc[0] >= 22);
      chk("single_gap", {31'd0, ok}, 32'd1);
      exp_q = '{8'h2A, 8'h2B};
      check_log("single");

      // Packet lock holds off a command written mid-packet
      busy_len = 3;
      sq = '{{1'b0, 8'h10}, {1'b0, 8'h11}, {1'b1, 8'h12}};
      drive_stream();
      for (int i = 0; i < 50 && sq.size() == 3; i++) tick();
      chk("lock_first_accept", sq.size(), 32'd2);
      cmd(8'h21);
      run(40);
      exp_q = '{8'h10, 8'h11, 8'h12, 8'h21};
      check_log("lock");

      // Buffered command wins over a waiting stream byte at a packet boundary
      busy_len = 8;
      cmd(8'h07);
      run(3);
      cmd(8'h41);
      sq.push_back({1'b1, 8'h55});
      drive_stream();
      run(40);
      exp_q = '{8'h07, 8'h41, 8'h55};
      check_log("prio");

      // Overflow, clear, then a push on the pop edge of a full FIFO
      busy_len = 40;
      cmd(8'h0F);
      run(3);
      busy_len = 2;
      for (int b = 1; b <= 5; b++) cmd(8'(b));
      chk("ovf_level", {29'd0, bus.cmd_level}, 32'd4);
      chk("ovf_flag", {31'd0, bus.cmd_overflow}, 32'd1);
      bus.clr_overflow = 1'b1;
      tick();
      chk("ovf_clear", {31'd0, bus.cmd_overflow}, 32'd0);
      for (int i = 0; i < 100 && cyc < m_avail; i++) tick();
      cmd(8'h09);
      chk("popfull_level", {29'd0, bus.cmd_level}, 32'd4);
      chk("popfull_ovf", {31'd0, bus.cmd_overflow}, 32'd0);
      run(60);
      exp_q = '{8'h0F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h09};
      check_log("ovf");

      // Reset while waiting on the UART with lock set and a command pending
      busy_len = 10;
      sq = '{{1'b0, 8'hA0}, {1'b0, 8'hA1}, {1'b1, 8'hA2}};
      drive_stream();
      for (int i = 0; i < 50 && sq.size() == 3; i++) tick();
      sv_gate = 1'b0;
      drive_stream();
      cmd(8'h31);
      run(4);
      rst = 1'b1;
      #1;
      chk("rst_mid_tx_wr", {31'd0, bus.tx_wr}, 32'd0);
      chk("rst_mid_level", {29'd0, bus.cmd_level}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (busy_cnt > 0) busy_cnt--;
      bus.tx_busy = (busy_cnt > 0);
      model_reset();
      rst = 1'b0;
      sv_gate = 1'b1;
      drive_stream();
      run(2);
      cmd(8'h32);
      tick();
      chk("rst_latency_wr", {31'd0, bus.tx_wr}, 32'd1);
      chk("rst_latency_data", {24'd0, bus.tx_data}, 32'h32);
      run(20);
      exp_q = '{8'hA0, 8'h32};
      check_log("rst");

      // Randomized traffic
      for (int c = 0; c < 2000; c++) begin
         busy_len = $urandom_range(0, 6);
         if ($urandom_range(0, 9) < 3) begin
            bus.cmd_wr   = 1'b1;
            bus.cmd_data = 8'($urandom);
         end
         bus.clr_overflow = ($urandom_range(0, 49) == 0);
         if (sq.size() == 0 && $urandom_range(0, 9) < 2) begin
            int n;
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) sq.push_back({(k == n - 1), 8'($urandom)});
         end
         sv_gate = ($urandom_range(0, 3) != 0);
         drive_stream();
         tick();
      end
      sv_gate = 1'b1;
      drive_stream();
      run(150);
      chk("drain_stream", sq.size(), 32'd0);
      chk("drain_level", {29'd0, bus.cmd_level}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between the command FSM's byte writes (echo, ACK `*`, error `!`, status and data-length readback) and the bulk sample readout stream. Command bytes arrive as one-cycle write pulses with no backpressure, so they are buffered in a small FIFO. Stream bytes use a valid/ready handshake and are packet-locked: one stream packet is never interleaved with command bytes. The block sits between the command FSM / readout logic and the UART TX core.

## Interface
- CMD_DEPTH, 4, command FIFO depth in entries; power of 2, 2..16
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_data  in  8  command FSM byte
- cmd_wr  in  1  one-cycle write pulse; no backpressure
- stream_data  in  8  readout byte
- stream_valid  in  1  stream byte available
- stream_last  in  1  qualifies the final byte of a packet; sampled with stream_valid
- stream_ready  out  1  combinational; a byte transfers at the clock edge where stream_valid and stream_ready are both 1
- tx_data  out  8  byte to the UART core; registered, held stable until the next load
- tx_wr  out  1  one-cycle write strobe to the UART core
- tx_busy  in  1  UART core busy; rises the cycle after tx_wr and stays high until the byte is shifted out
- clr_overflow  in  1  clears cmd_overflow
- cmd_overflow  out  1  sticky flag: a command byte was dropped
- cmd_level  out  $clog2(CMD_DEPTH)+1  command FIFO occupancy

## Operation
- Reset values:
  - State = IDLE; FIFO empty with both pointers at 0.
  - cmd_level = 0, lock = 0, tx_data = 0, tx_wr = 0, cmd_overflow = 0.
- Command FIFO:
  - cmd_wr with the FIFO not full writes one entry.
  - cmd_wr with the FIFO full and no pop in the same cycle drops the byte and sets cmd_overflow.
  - A push and a pop in the same cycle both take effect; cmd_level is unchanged. This includes a push to a full FIFO during a pop, which is not dropped.
  - Pointers wrap modulo CMD_DEPTH.
- cmd_overflow:
  - Set by a drop, cleared by clr_overflow.
  - A drop and clr_overflow in the same cycle leaves cmd_overflow = 1.
- Lock flag:
  - Set when a stream byte with stream_last = 0 is accepted.
  - Cleared when a stream byte with stream_last = 1 is accepted.
- Arbitration, evaluated only in IDLE:
  - lock = 1: stream only. stream_ready = stream_valid. Command bytes wait in the FIFO.
  - lock = 0 and FIFO not empty: pop the FIFO head into tx_data. stream_ready = 0.
  - lock = 0, FIFO empty, stream_valid = 1: stream_ready = 1; accept stream_data into tx_data.
  - On any grant, go to SEND.
- States:
  - IDLE: arbitrate as above; with nothing to send, stay in IDLE.
  - SEND: tx_wr = 1 for exactly this cycle. Go to HOLD.
  - HOLD: tx_busy is ignored for this one cycle. Go to WAIT.
  - WAIT: stay while tx_busy = 1; go to IDLE when tx_busy = 0.
- stream_ready is 0 in every state except IDLE.
- A single-byte packet (stream_last = 1 on the first byte) never sets lock.
- Reset mid-operation:
  - All state, the FIFO and lock clear immediately.
  - A byte already handed to the UART core completes in the core; the arbiter does not re-send it.

## Timing
- Command latency: cmd_wr at edge N into an empty FIFO, arbiter in IDLE → pop at edge N+1 → tx_wr high in cycle N+1..N+2, with tx_data valid.
- Stream latency: handshake at edge N → tx_wr high in the following cycle.
- Minimum byte period is 4 cycles (SEND, HOLD, WAIT with tx_busy already 0, IDLE). In practice it is bounded by the UART bit rate.
- tx_data changes only on a grant edge. It is stable through SEND, HOLD and WAIT.
- cmd_level updates on the edge after push/pop.

## Test plan
- Single command byte: cmd_wr with 0x2A; UART model busy for 20 cycles → exactly one tx_wr, tx_data = 0x2A; cmd_level goes 1 → 0; the next tx_wr comes no earlier than 22 cycles later.
- Packet lock: stream packet 0x10, 0x11, 0x12 (last on 0x12). Pulse cmd_wr 0x21 after 0x10 is accepted → UART sees 0x10, 0x11, 0x12, 0x21 in that order; stream_ready stays 0 while the command FIFO drains.
- Command priority at a boundary: FIFO holds 0x41 and stream_valid is asserted with lock = 0 → 0x41 is sent first, then the stream byte.
- Overflow: CMD_DEPTH = 4, tx_busy held high, 5 cmd_wr pulses 0x01..0x05 → cmd_level = 4, cmd_overflow = 1. After release the output is 0x01..0x04 (0x05 dropped). clr_overflow → cmd_overflow = 0.
- Push to a full FIFO on the pop cycle: FIFO full, release tx_busy, cmd_wr 0x09 on the pop edge → no overflow, cmd_level stays 4, 0x09 is eventually sent.
- Reset mid-packet: assert rst during WAIT with lock = 1 and the FIFO non-empty → tx_wr = 0, cmd_level = 0, lock = 0 immediately. After release, a new command byte is sent with 2-cycle latency.
